// File: rtl/lsu_mem_controller.sv
// Load/store unit memory sequencer: issues one data-memory access per load/store and formats data.
// Latency: minimum 3 cycles per access (IDLE accept -> WAIT -> DONE), longer while memory is slow.
// Backpressure: request held in WAIT until dm_valid_i or timeout; stall_o freezes the pipeline meanwhile.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   Load, Store, fun3   decoded access kind and size/sign from the execute stage
//   addr_i              byte address from the ALU
//   store_data_i        rs2 value for stores
//   dm_rdata_i          memory read word, qualified by dm_valid_i
//   dm_valid_i          memory response / write acknowledge
//   dm_req_o, dm_we_o   memory request (held until answered) and write enable
//   dm_addr_o           word-aligned memory address
//   dm_wdata_o          lane-replicated store data
//   dm_wmask_o          byte-lane enables, zero whenever no request is active
//   stall_o             freeze fetch/decode/execute while an access is in flight
//   load_data_o         formatted load result, held until the next completed load
//   load_done_o         one-cycle pulse when an access finishes (loads and stores)
//   access_err_o        one-cycle pulse for misaligned address or illegal fun3
//   timeout_o           one-cycle pulse when memory failed to answer in time

module lsu_mem_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int FUNCTION3      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Load,
  input  logic                  Store,
  input  logic [FUNCTION3-1:0]  fun3,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  input  logic                  dm_valid_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  output logic [3:0]            dm_wmask_o,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] load_data_o,
  output logic                  load_done_o,
  output logic                  access_err_o,
  output logic                  timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // fun3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            fun3_q, fun3_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic                  stall;

  // ---------------------------------------------------------------------------
  // Request decode in IDLE. Load has priority when both strobes are high.
  // ---------------------------------------------------------------------------
  logic       is_load;
  logic       req_any;
  logic [2:0] f3;
  logic [1:0] a_lo;
  logic       fun3_legal;
  logic       misaligned;
  logic       access_ok;

  assign is_load = Load;
  assign req_any = Load | Store;
  assign f3      = fun3[2:0];
  assign a_lo    = addr_i[1:0];

  always_comb begin
    fun3_legal = 1'b0;
    if (is_load) begin
      fun3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    end else begin
      fun3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
  end

  // Size lives in fun3[1:0] for both loads and stores: 00 byte, 01 half, 10 word.
  always_comb begin
    misaligned = 1'b0;
    case (f3[1:0])
      2'b01:   misaligned = a_lo[0];
      2'b10:   misaligned = (a_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign access_ok = fun3_legal && !misaligned;

  // ---------------------------------------------------------------------------
  // Store lane formatting, computed from the live inputs and latched on accept.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_wmask;

  always_comb begin
    st_wdata = store_data_i;
    st_wmask = 4'b1111;
    case (f3[1:0])
      2'b00: begin
        st_wdata = {4{store_data_i[7:0]}};
        st_wmask = 4'b0001 << a_lo;
      end
      2'b01: begin
        st_wdata = {2{store_data_i[15:0]}};
        st_wmask = a_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = store_data_i;
        st_wmask = 4'b1111;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load formatting from the latched access and the returning memory word.
  // ---------------------------------------------------------------------------
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_fmt;

  assign ld_byte = dm_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = dm_rdata_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_fmt = dm_rdata_i;
    case (fun3_q)
      F3_B:    ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_fmt = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_fmt = {24'h000000, ld_byte};
      F3_HU:   ld_fmt = {16'h0000, ld_half};
      default: ld_fmt = dm_rdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_inc;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    fun3_d      = fun3_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    load_data_d = load_data_q;
    err_d       = 1'b0;
    timeout_d   = 1'b0;
    stall       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // Reset gates acceptance so no output asserts while rst is held.
        if (!rst && req_any) begin
          if (access_ok) begin
            addr_d  = addr_i;
            fun3_d  = f3;
            we_d    = !is_load;
            wdata_d = is_load ? '0 : st_wdata;
            wmask_d = is_load ? 4'b0000 : st_wmask;
            stall   = 1'b1;
            state_d = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_inc;
        // A response arriving on the timeout cycle still completes normally.
        if (dm_valid_i) begin
          if (!we_q) begin
            load_data_d = ld_fmt;
          end
          state_d = S_DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_d   = 1'b1;
          load_data_d = '0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        // The finished instruction is still in execute; its strobes are ignored.
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      fun3_q      <= 3'b000;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= 4'b0000;
      load_data_q <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      fun3_q      <= fun3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dm_req_o     = (state_q == S_WAIT);
  assign dm_we_o      = dm_req_o & we_q;
  assign dm_addr_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign dm_wdata_o   = wdata_q;
  assign dm_wmask_o   = dm_req_o ? wmask_q : 4'b0000;
  assign stall_o      = stall;
  assign load_data_o  = load_data_q;
  assign load_done_o  = (state_q == S_DONE);
  assign access_err_o = err_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Directed bench for lsu_mem_controller: stores, loads, errors, timeout, reset abort, back-to-back.
// Latency: expectations follow the 3-cycle minimum IDLE -> WAIT -> DONE sequence.
// Backpressure: memory responses are driven by hand at chosen WAIT cycles.

module tb_lsu_mem_controller;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  fun3;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic [31:0] rdata;
  logic        dvalid;
  logic        req;
  logic        we;
  logic [31:0] daddr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        stall;
  logic [31:0] ldata;
  logic        ldone;
  logic        aerr;
  logic        tout;

  int n_pass;
  int n_fail;
  int n_total;

  lsu_mem_controller #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .FUNCTION3     (3),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Load         (load),
    .Store        (store),
    .fun3         (fun3),
    .addr_i       (addr),
    .store_data_i (sdata),
    .dm_rdata_i   (rdata),
    .dm_valid_i   (dvalid),
    .dm_req_o     (req),
    .dm_we_o      (we),
    .dm_addr_o    (daddr),
    .dm_wdata_o   (wdata),
    .dm_wmask_o   (wmask),
    .stall_o      (stall),
    .load_data_o  (ldata),
    .load_done_o  (ldone),
    .access_err_o (aerr),
    .timeout_o    (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    rst    = 1'b1;
    load   = 1'b0;
    store  = 1'b0;
    fun3   = 3'b000;
    addr   = 32'h0;
    sdata  = 32'h0;
    rdata  = 32'h0;
    dvalid = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req",   {31'b0, req},   32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_done",  {31'b0, ldone}, 32'h0);
    chk("rst_err",   {31'b0, aerr},  32'h0);
    chk("rst_tout",  {31'b0, tout},  32'h0);
    chk("rst_mask",  {28'b0, wmask}, 32'h0);
    chk("rst_ldata", ldata,          32'h0);
    next_cyc();
    rst = 1'b0;

    // ---------------- SW 0x104, answered on second WAIT cycle ----------------
    store = 1'b1; fun3 = 3'b010; addr = 32'h104; sdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("sw_idle_stall", {31'b0, stall}, 32'h1);
    chk("sw_idle_req",   {31'b0, req},   32'h0);
    next_cyc();
    @(negedge clk);
    chk("sw_w1_req",   {31'b0, req},   32'h1);
    chk("sw_w1_we",    {31'b0, we},    32'h1);
    chk("sw_w1_mask",  {28'b0, wmask}, 32'hF);
    chk("sw_w1_addr",  daddr,          32'h104);
    chk("sw_w1_wdata", wdata,          32'hDEADBEEF);
    chk("sw_w1_stall", {31'b0, stall}, 32'h1);
    next_cyc();
    dvalid = 1'b1;
    @(negedge clk);
    chk("sw_w2_req", {31'b0, req}, 32'h1);
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("sw_done_req",   {31'b0, req},   32'h0);
    chk("sw_done_mask",  {28'b0, wmask}, 32'h0);
    chk("sw_done_pulse", {31'b0, ldone}, 32'h1);
    chk("sw_done_stall", {31'b0, stall}, 32'h0);
    chk("sw_done_tout",  {31'b0, tout},  32'h0);
    next_cyc();
    store = 1'b0;
    @(negedge clk);
    chk("sw_idle2_done", {31'b0, ldone}, 32'h0);
    chk("sw_idle2_req",  {31'b0, req},   32'h0);

    // ---------------- LB 0x203 ----------------
    next_cyc();
    load = 1'b1; fun3 = 3'b000; addr = 32'h203;
    @(negedge clk);
    chk("lb_idle_stall", {31'b0, stall}, 32'h1);
    next_cyc();
    load = 1'b0; dvalid = 1'b1; rdata = 32'h80FF_FFFF;
    @(negedge clk);
    chk("lb_w_req",  {31'b0, req},   32'h1);
    chk("lb_w_we",   {31'b0, we},    32'h0);
    chk("lb_w_addr", daddr,          32'h200);
    chk("lb_w_mask", {28'b0, wmask}, 32'h0);
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("lb_done",  {31'b0, ldone}, 32'h1);
    chk("lb_ldata", ldata,          32'hFFFFFF80);

    // ---------------- LBU 0x203 ----------------
    next_cyc();
    load = 1'b1; fun3 = 3'b100; addr = 32'h203;
    next_cyc();
    load = 1'b0; dvalid = 1'b1; rdata = 32'h80FF_FFFF;
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("lbu_done",  {31'b0, ldone}, 32'h1);
    chk("lbu_ldata", ldata,          32'h00000080);

    // ---------------- dm_valid outside WAIT is ignored ----------------
    next_cyc();
    dvalid = 1'b1; rdata = 32'h12345678;
    @(negedge clk);
    chk("spur_req", {31'b0, req}, 32'h0);
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("spur_done",  {31'b0, ldone}, 32'h0);
    chk("spur_ldata", ldata,          32'h00000080);

    // ---------------- SH 0x02 ----------------
    next_cyc();
    store = 1'b1; fun3 = 3'b001; addr = 32'h2; sdata = 32'h1234ABCD;
    next_cyc();
    store = 1'b0; dvalid = 1'b1;
    @(negedge clk);
    chk("sh_mask",  {28'b0, wmask}, 32'hC);
    chk("sh_wdata", wdata,          32'hABCDABCD);
    chk("sh_addr",  daddr,          32'h0);
    chk("sh_we",    {31'b0, we},    32'h1);
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("sh_done",       {31'b0, ldone}, 32'h1);
    chk("sh_ldata_hold", ldata,          32'h00000080);

    // ---------------- SB 0x01 ----------------
    next_cyc();
    store = 1'b1; fun3 = 3'b000; addr = 32'h1; sdata = 32'hCAFE_0077;
    next_cyc();
    store = 1'b0; dvalid = 1'b1;
    @(negedge clk);
    chk("sb_mask",  {28'b0, wmask}, 32'h2);
    chk("sb_wdata", wdata,          32'h77777777);
    next_cyc();
    dvalid = 1'b0;

    // ---------------- LH 0x01: misaligned ----------------
    next_cyc();
    load = 1'b1; fun3 = 3'b001; addr = 32'h1;
    @(negedge clk);
    chk("lh_mis_stall", {31'b0, stall}, 32'h0);
    next_cyc();
    load = 1'b0;
    @(negedge clk);
    chk("lh_mis_err", {31'b0, aerr},  32'h1);
    chk("lh_mis_req", {31'b0, req},   32'h0);
    next_cyc();
    @(negedge clk);
    chk("lh_mis_err_clr", {31'b0, aerr}, 32'h0);

    // ---------------- store with illegal fun3 ----------------
    store = 1'b1; fun3 = 3'b011; addr = 32'h0;
    next_cyc();
    store = 1'b0;
    @(negedge clk);
    chk("st_ill_err", {31'b0, aerr}, 32'h1);
    chk("st_ill_req", {31'b0, req},  32'h0);

    // ---------------- LW 0x10 with no response: timeout ----------------
    next_cyc();
    load = 1'b1; fun3 = 3'b010; addr = 32'h10;
    next_cyc();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_req",  {31'b0, req},  32'h1);
      chk("to_wait_tout", {31'b0, tout}, 32'h0);
      next_cyc();
    end
    @(negedge clk);
    chk("to_req",   {31'b0, req},   32'h0);
    chk("to_pulse", {31'b0, tout},  32'h1);
    chk("to_done",  {31'b0, ldone}, 32'h1);
    chk("to_ldata", ldata,          32'h0);
    next_cyc();
    @(negedge clk);
    chk("to_clr",   {31'b0, tout},  32'h0);
    chk("to_idle",  {31'b0, req},   32'h0);
    chk("to_stall", {31'b0, stall}, 32'h0);

    // ---------------- Load and Store together, then reset in WAIT ----------------
    next_cyc();
    load = 1'b1; store = 1'b1; fun3 = 3'b010; addr = 32'h20; sdata = 32'hFFFFFFFF;
    next_cyc();
    @(negedge clk);
    chk("both_req",  {31'b0, req},   32'h1);
    chk("both_we",   {31'b0, we},    32'h0);
    chk("both_mask", {28'b0, wmask}, 32'h0);
    rst = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("rst_wait_req",   {31'b0, req},   32'h0);
    chk("rst_wait_done",  {31'b0, ldone}, 32'h0);
    chk("rst_wait_stall", {31'b0, stall}, 32'h0);
    next_cyc();
    rst = 1'b0; load = 1'b0; store = 1'b0;
    @(negedge clk);
    chk("rst_after_req", {31'b0, req}, 32'h0);

    // ---------------- back-to-back LW with 1-cycle memory ----------------
    next_cyc();
    load = 1'b1; fun3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    chk("b2b1_idle_stall", {31'b0, stall}, 32'h1);
    next_cyc();
    dvalid = 1'b1; rdata = 32'h11111111;
    @(negedge clk);
    chk("b2b1_w_stall", {31'b0, stall}, 32'h1);
    chk("b2b1_w_addr",  daddr,          32'h40);
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("b2b1_done_stall", {31'b0, stall}, 32'h0);
    chk("b2b1_done",       {31'b0, ldone}, 32'h1);
    chk("b2b1_ldata",      ldata,          32'h11111111);
    chk("b2b1_done_req",   {31'b0, req},   32'h0);
    next_cyc();
    addr = 32'h44;
    @(negedge clk);
    chk("b2b2_idle_stall", {31'b0, stall}, 32'h1);
    chk("b2b2_idle_req",   {31'b0, req},   32'h0);
    next_cyc();
    load = 1'b0; dvalid = 1'b1; rdata = 32'h22222222;
    @(negedge clk);
    chk("b2b2_w_req",  {31'b0, req}, 32'h1);
    chk("b2b2_w_addr", daddr,        32'h44);
    next_cyc();
    dvalid = 1'b0;
    @(negedge clk);
    chk("b2b2_done",  {31'b0, ldone}, 32'h1);
    chk("b2b2_ldata", ldata,          32'h22222222);
    next_cyc();
    @(negedge clk);
    chk("b2b_end_stall", {31'b0, stall}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
